// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - registered dispatch queue with operand resolution
//
// Purpose: buffers decoded instructions in a QUEUE_DEPTH-entry FIFO, resolves
// the head instruction's source operands (RF, then ROB, then CDB snoop) and
// pops at most one instruction per cycle into a registered dispatch output
// when the ROB and the target unit (RS or LSB) both have room.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global stall when low),
//   flush_in (synchronous queue clear)
//   dec_*        decoder push side; dec_ready = queue not full
//   rf_*         head source register lookup (idx out, busy/val/tag in)
//   rob_rs*      ROB result lookup for the RF rename tags
//   rob_nex_idx  tag given to the instruction popped this cycle
//   *_full       downstream back-pressure
//   cdb_*        CDB_PORTS broadcast ports, port i at [i*W +: W]
//   dis_*, *_flag registered dispatch output; rob_flag mirrors dis_valid
module dispatch_queue #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ROB_IDX_W   = 4,
  parameter int REG_IDX_W   = 5,
  parameter int CDB_PORTS   = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic                          dec_valid,
  output logic                          dec_ready,
  input  logic [5:0]                    dec_op,
  input  logic [31:0]                   dec_imm,
  input  logic [31:0]                   dec_pc,
  input  logic [31:0]                   dec_btb_pc,
  input  logic                          dec_btb_predict,
  input  logic [REG_IDX_W-1:0]          dec_rd,
  input  logic [REG_IDX_W-1:0]          dec_rs1,
  input  logic [REG_IDX_W-1:0]          dec_rs2,
  input  logic                          dec_use_rs1,
  input  logic                          dec_use_rs2,
  output logic [REG_IDX_W-1:0]          rf_rs1_idx,
  output logic [REG_IDX_W-1:0]          rf_rs2_idx,
  input  logic                          rf_rs1_busy,
  input  logic                          rf_rs2_busy,
  input  logic [31:0]                   rf_rs1_val,
  input  logic [31:0]                   rf_rs2_val,
  input  logic [ROB_IDX_W-1:0]          rf_rs1_tag,
  input  logic [ROB_IDX_W-1:0]          rf_rs2_tag,
  output logic [ROB_IDX_W-1:0]          rob_rs1_idx,
  output logic [ROB_IDX_W-1:0]          rob_rs2_idx,
  input  logic                          rob_rs1_ready,
  input  logic                          rob_rs2_ready,
  input  logic [31:0]                   rob_rs1_val,
  input  logic [31:0]                   rob_rs2_val,
  input  logic [ROB_IDX_W-1:0]          rob_nex_idx,
  input  logic                          rob_full,
  input  logic                          rs_full,
  input  logic                          lsb_full,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_IDX_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*32-1:0]       cdb_val,
  output logic                          dis_valid,
  output logic                          rob_flag,
  output logic                          rs_flag,
  output logic                          lsb_flag,
  output logic                          rf_write_flag,
  output logic [5:0]                    dis_op,
  output logic [31:0]                   dis_imm,
  output logic [31:0]                   dis_pc,
  output logic [31:0]                   dis_btb_pc,
  output logic                          dis_btb_predict,
  output logic [REG_IDX_W-1:0]          dis_rd,
  output logic [ROB_IDX_W-1:0]          dis_rob_idx,
  output logic                          dis_r1,
  output logic                          dis_r2,
  output logic [31:0]                   dis_v1,
  output logic [31:0]                   dis_v2,
  output logic [ROB_IDX_W-1:0]          dis_q1,
  output logic [ROB_IDX_W-1:0]          dis_q2
);

  // Shared opcode encoding: conditional branches, loads and stores are
  // contiguous ranges.
  localparam logic [5:0] OP_BEQ  = 6'd5;
  localparam logic [5:0] OP_BGEU = 6'd10;
  localparam logic [5:0] OP_LB   = 6'd11;
  localparam logic [5:0] OP_LHU  = 6'd15;
  localparam logic [5:0] OP_SB   = 6'd16;
  localparam logic [5:0] OP_SW   = 6'd18;

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef struct packed {
    logic [5:0]           op;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [31:0]          btb_pc;
    logic                 btb_predict;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 use_rs1;
    logic                 use_rs2;
  } entry_t;

  typedef struct packed {
    logic                 r;
    logic [31:0]          v;
    logic [ROB_IDX_W-1:0] q;
  } opnd_t;

  entry_t               mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]     head, tail;
  logic [PTR_W:0]       count;
  entry_t               hd;
  logic                 is_load, is_store, is_branch, unit_full;
  logic                 push, pop;
  opnd_t                op1, op2;

  function automatic opnd_t resolve(
    input logic                           use_rs,
    input logic [REG_IDX_W-1:0]           rs,
    input logic                           busy,
    input logic [31:0]                    rf_val,
    input logic [ROB_IDX_W-1:0]           tag,
    input logic                           rob_ready,
    input logic [31:0]                    rob_val,
    input logic                           fwd_en,
    input logic [REG_IDX_W-1:0]           fwd_rd,
    input logic [ROB_IDX_W-1:0]           fwd_tag,
    input logic [CDB_PORTS-1:0]           cv,
    input logic [CDB_PORTS*ROB_IDX_W-1:0] ct,
    input logic [CDB_PORTS*32-1:0]        cval
  );
    opnd_t o;
    o.r = 1'b0;
    o.v = 32'd0;
    o.q = tag;
    if (!use_rs || rs == '0) begin
      o.r = 1'b1;
      o.q = '0;
    end else if (fwd_en && fwd_rd == rs) begin
      // Last cycle's dispatch renamed rs, but the RF has not seen it yet.
      o.q = fwd_tag;
    end else if (!busy) begin
      o.r = 1'b1;
      o.v = rf_val;
      o.q = '0;
    end else if (rob_ready) begin
      o.r = 1'b1;
      o.v = rob_val;
      o.q = '0;
    end else begin
      // Descending scan so the lowest matching port is written last.
      for (int i = CDB_PORTS - 1; i >= 0; i--) begin
        if (cv[i] && ct[i*ROB_IDX_W +: ROB_IDX_W] == tag) begin
          o.r = 1'b1;
          o.v = cval[i*32 +: 32];
          o.q = '0;
        end
      end
    end
    return o;
  endfunction

  assign hd          = mem[head];
  assign is_branch   = (hd.op >= OP_BEQ) && (hd.op <= OP_BGEU);
  assign is_load     = (hd.op >= OP_LB)  && (hd.op <= OP_LHU);
  assign is_store    = (hd.op >= OP_SB)  && (hd.op <= OP_SW);
  assign unit_full   = (is_load || is_store) ? lsb_full : rs_full;

  assign dec_ready   = (count != (PTR_W+1)'(QUEUE_DEPTH));
  assign push        = dec_valid && dec_ready && rdy_in && !flush_in;
  assign pop         = (count != '0) && rdy_in && !flush_in && !rob_full && !unit_full;

  assign rf_rs1_idx  = hd.rs1;
  assign rf_rs2_idx  = hd.rs2;
  assign rob_rs1_idx = rf_rs1_tag;
  assign rob_rs2_idx = rf_rs2_tag;
  assign rob_flag    = dis_valid;

  assign op1 = resolve(hd.use_rs1, hd.rs1, rf_rs1_busy, rf_rs1_val, rf_rs1_tag,
                       rob_rs1_ready, rob_rs1_val, dis_valid && rf_write_flag,
                       dis_rd, dis_rob_idx, cdb_valid, cdb_tag, cdb_val);
  assign op2 = resolve(hd.use_rs2, hd.rs2, rf_rs2_busy, rf_rs2_val, rf_rs2_tag,
                       rob_rs2_ready, rob_rs2_val, dis_valid && rf_write_flag,
                       dis_rd, dis_rob_idx, cdb_valid, cdb_tag, cdb_val);

  // Entry storage needs no reset: only slots between head and tail are read.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[tail] <= '{op: dec_op, imm: dec_imm, pc: dec_pc, btb_pc: dec_btb_pc,
                     btb_predict: dec_btb_predict, rd: dec_rd, rs1: dec_rs1,
                     rs2: dec_rs2, use_rs1: dec_use_rs1, use_rs2: dec_use_rs2};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dis_valid       <= 1'b0;
      rs_flag         <= 1'b0;
      lsb_flag        <= 1'b0;
      rf_write_flag   <= 1'b0;
      dis_op          <= '0;
      dis_imm         <= '0;
      dis_pc          <= '0;
      dis_btb_pc      <= '0;
      dis_btb_predict <= 1'b0;
      dis_rd          <= '0;
      dis_rob_idx     <= '0;
      dis_r1          <= 1'b0;
      dis_r2          <= 1'b0;
      dis_v1          <= '0;
      dis_v2          <= '0;
      dis_q1          <= '0;
      dis_q2          <= '0;
    end else if (pop) begin
      dis_valid       <= 1'b1;
      rs_flag         <= !(is_load || is_store);
      lsb_flag        <= is_load || is_store;
      rf_write_flag   <= !(is_store || is_branch);
      dis_op          <= hd.op;
      dis_imm         <= hd.imm;
      dis_pc          <= hd.pc;
      dis_btb_pc      <= hd.btb_pc;
      dis_btb_predict <= hd.btb_predict;
      dis_rd          <= hd.rd;
      dis_rob_idx     <= rob_nex_idx;
      dis_r1          <= op1.r;
      dis_r2          <= op2.r;
      dis_v1          <= op1.v;
      dis_v2          <= op2.v;
      dis_q1          <= op1.q;
      dis_q2          <= op2.q;
    end else begin
      // Data fields hold; only the valid/enable bits drop.
      dis_valid       <= 1'b0;
      rs_flag         <= 1'b0;
      lsb_flag        <= 1'b0;
      rf_write_flag   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - directed self-checking bench for dispatch_queue
module tb_dispatch_queue;

  localparam logic [5:0] OP_BEQ  = 6'd5;
  localparam logic [5:0] OP_LW   = 6'd13;
  localparam logic [5:0] OP_SW   = 6'd18;
  localparam logic [5:0] OP_ADDI = 6'd19;
  localparam logic [5:0] OP_ADD  = 6'd28;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        dec_valid, dec_ready;
  logic [5:0]  dec_op;
  logic [31:0] dec_imm, dec_pc, dec_btb_pc;
  logic        dec_btb_predict;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_use_rs1, dec_use_rs2;
  logic [4:0]  rf_rs1_idx, rf_rs2_idx;
  logic        rf_rs1_busy, rf_rs2_busy;
  logic [31:0] rf_rs1_val, rf_rs2_val;
  logic [3:0]  rf_rs1_tag, rf_rs2_tag;
  logic [3:0]  rob_rs1_idx, rob_rs2_idx;
  logic        rob_rs1_ready, rob_rs2_ready;
  logic [31:0] rob_rs1_val, rob_rs2_val;
  logic [3:0]  rob_nex_idx;
  logic        rob_full, rs_full, lsb_full;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_val;
  logic        dis_valid, rob_flag, rs_flag, lsb_flag, rf_write_flag;
  logic [5:0]  dis_op;
  logic [31:0] dis_imm, dis_pc, dis_btb_pc;
  logic        dis_btb_predict;
  logic [4:0]  dis_rd;
  logic [3:0]  dis_rob_idx;
  logic        dis_r1, dis_r2;
  logic [31:0] dis_v1, dis_v2;
  logic [3:0]  dis_q1, dis_q2;

  int total = 0;
  int bad   = 0;

  dispatch_queue #(.QUEUE_DEPTH(4), .ROB_IDX_W(4), .REG_IDX_W(5), .CDB_PORTS(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_btb_pc(dec_btb_pc),
    .dec_btb_predict(dec_btb_predict), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
    .rf_rs1_busy(rf_rs1_busy), .rf_rs2_busy(rf_rs2_busy),
    .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .rf_rs1_tag(rf_rs1_tag), .rf_rs2_tag(rf_rs2_tag),
    .rob_rs1_idx(rob_rs1_idx), .rob_rs2_idx(rob_rs2_idx),
    .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
    .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
    .rob_nex_idx(rob_nex_idx), .rob_full(rob_full), .rs_full(rs_full),
    .lsb_full(lsb_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .dis_valid(dis_valid), .rob_flag(rob_flag),
    .rs_flag(rs_flag), .lsb_flag(lsb_flag), .rf_write_flag(rf_write_flag),
    .dis_op(dis_op), .dis_imm(dis_imm), .dis_pc(dis_pc),
    .dis_btb_pc(dis_btb_pc), .dis_btb_predict(dis_btb_predict),
    .dis_rd(dis_rd), .dis_rob_idx(dis_rob_idx), .dis_r1(dis_r1),
    .dis_r2(dis_r2), .dis_v1(dis_v1), .dis_v2(dis_v2), .dis_q1(dis_q1),
    .dis_q2(dis_q2)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_dec(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [31:0] imm);
    dec_valid = 1'b1; dec_op = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_imm = imm;
    dec_pc = {16'h0, 11'h0, rd} << 2; dec_btb_pc = 32'h0; dec_btb_predict = 1'b0;
  endtask

  task automatic lookups_idle();
    rf_rs1_busy = 0; rf_rs2_busy = 0; rf_rs1_val = 32'h11; rf_rs2_val = 32'h22;
    rf_rs1_tag = 0; rf_rs2_tag = 0; rob_rs1_ready = 0; rob_rs2_ready = 0;
    rob_rs1_val = 0; rob_rs2_val = 0; cdb_valid = 0; cdb_tag = 0; cdb_val = 0;
  endtask

  initial begin
    rst_in = 0; rdy_in = 1; flush_in = 0; dec_valid = 0;
    set_dec(OP_ADDI, 0, 0, 0, 0, 0, 0); dec_valid = 0;
    lookups_idle();
    rob_nex_idx = 0; rob_full = 0; rs_full = 0; lsb_full = 0;
    tick(); tick();
    check_eq("rst_dis_valid", dis_valid, 0);
    check_eq("rst_flags", {rob_flag, rs_flag, lsb_flag, rf_write_flag}, 0);
    check_eq("rst_rob_idx", dis_rob_idx, 0);
    check_eq("rst_dec_ready", dec_ready, 1);
    rst_in = 1;

    // ADDI x1,x0,5 then ADD x2,x1,x1: second sees the in-flight rename
    set_dec(OP_ADDI, 1, 0, 0, 1, 0, 5);
    tick();
    set_dec(OP_ADD, 2, 1, 1, 1, 1, 0);
    rob_nex_idx = 3;
    tick();
    check_eq("addi_valid", dis_valid, 1);
    check_eq("addi_rob_idx", dis_rob_idx, 3);
    check_eq("addi_r1v1", {dis_r1, dis_v1[30:0]}, 32'h8000_0000);
    check_eq("addi_imm", dis_imm, 5);
    check_eq("addi_flags", {rs_flag, lsb_flag, rf_write_flag}, 3'b101);
    dec_valid = 0; rob_nex_idx = 4;
    check_eq("add_rf_idx", rf_rs1_idx, 1);
    tick();
    check_eq("add_rob_idx", dis_rob_idx, 4);
    check_eq("add_r1r2", {dis_r1, dis_r2}, 0);
    check_eq("add_q1q2", {dis_q1, dis_q2}, 8'h33);
    check_eq("add_v1", dis_v1, 0);
    tick();
    check_eq("idle_valid", dis_valid, 0);

    // LW stalled by lsb_full for 3 cycles
    lsb_full = 1;
    set_dec(OP_LW, 3, 0, 0, 1, 0, 8);
    tick();
    dec_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("lw_stall_valid", dis_valid, 0);
    end
    lsb_full = 0; rob_nex_idx = 5;
    tick();
    check_eq("lw_valid", dis_valid, 1);
    check_eq("lw_flags", {rs_flag, lsb_flag, rf_write_flag}, 3'b011);
    check_eq("lw_rob_idx", dis_rob_idx, 5);

    // fill with rob_full, then drain back-to-back
    rob_full = 1;
    for (int i = 0; i < 4; i++) begin
      set_dec(OP_ADDI, 5'(10 + i), 0, 0, 1, 0, i);
      tick();
      check_eq("fill_no_dis", dis_valid, 0);
    end
    dec_valid = 0;
    check_eq("full_ready", dec_ready, 0);
    rob_full = 0;
    check_eq("full_ready_popcycle", dec_ready, 0);
    for (int i = 0; i < 4; i++) begin
      rob_nex_idx = 4'(8 + i);
      tick();
      check_eq("drain_valid", dis_valid, 1);
      check_eq("drain_rd", dis_rd, 10 + i);
      check_eq("drain_rob_idx", dis_rob_idx, 8 + i);
    end
    tick();
    check_eq("drain_done", dis_valid, 0);

    // ROB, CDB (lowest port wins) and unresolved paths
    set_dec(OP_ADD, 5, 6, 9, 1, 1, 0);
    tick();
    set_dec(OP_ADD, 6, 7, 8, 1, 1, 0);
    rf_rs1_busy = 1; rf_rs1_tag = 7; rob_rs1_ready = 0;
    rf_rs2_busy = 1; rf_rs2_tag = 4; rob_rs2_ready = 1; rob_rs2_val = 32'h55;
    cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd2}; cdb_val = {32'hDEADBEEF, 32'h1234};
    rob_nex_idx = 12;
    check_eq("cdb_rob_idx_out", rob_rs1_idx, 7);
    tick();
    check_eq("cdb_r1", dis_r1, 1);
    check_eq("cdb_v1", dis_v1, 32'hDEADBEEF);
    check_eq("cdb_q1", dis_q1, 0);
    check_eq("rob_v2", dis_v2, 32'h55);
    check_eq("rob_r2q2", {dis_r2, dis_q2}, 5'h10);
    dec_valid = 0;
    rf_rs2_tag = 9; rob_rs2_ready = 0;
    cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd7}; cdb_val = {32'hDEADBEEF, 32'hAAAA0000};
    tick();
    check_eq("cdb_low_wins", dis_v1, 32'hAAAA0000);
    check_eq("wait_r2", dis_r2, 0);
    check_eq("wait_q2", dis_q2, 9);
    check_eq("wait_v2", dis_v2, 0);
    lookups_idle();
    tick();

    // flush with 3 queued and a same-cycle push
    rob_full = 1;
    for (int i = 0; i < 3; i++) begin
      set_dec(OP_ADDI, 5'(40 - 32 + i), 0, 0, 1, 0, 0);
      tick();
    end
    flush_in = 1; rob_full = 0;
    set_dec(OP_ADDI, 30, 0, 0, 1, 0, 0);
    tick();
    flush_in = 0; dec_valid = 0;
    check_eq("flush_valid", dis_valid, 0);
    check_eq("flush_ready", dec_ready, 1);
    tick();
    check_eq("flush_empty", dis_valid, 0);
    rob_full = 1;
    for (int i = 0; i < 3; i++) begin
      set_dec(OP_ADDI, 5'(21 + i), 0, 0, 1, 0, 0);
      tick();
    end
    check_eq("flush_count3", dec_ready, 1);
    set_dec(OP_ADDI, 24, 0, 0, 1, 0, 0);
    tick();
    dec_valid = 0;
    check_eq("flush_count4", dec_ready, 0);
    rob_full = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_flush_rd", {dis_valid, 3'b0, dis_rd}, {1'b1, 3'b0, 5'(21 + i)});
    end
    tick();

    // store and branch flags, rdy_in stall
    set_dec(OP_SW, 0, 0, 0, 1, 1, 0);
    tick();
    set_dec(OP_BEQ, 0, 0, 0, 1, 1, 0);
    tick();
    check_eq("sw_flags", {dis_valid, rs_flag, lsb_flag, rf_write_flag}, 4'b1010);
    dec_valid = 0; rdy_in = 0;
    tick();
    check_eq("stall_valid", dis_valid, 0);
    rdy_in = 1;
    tick();
    check_eq("beq_flags", {dis_valid, rs_flag, lsb_flag, rf_write_flag}, 4'b1100);
    check_eq("beq_op", dis_op, OP_BEQ);

    // async reset mid-stream
    set_dec(OP_ADDI, 25, 0, 0, 1, 0, 0);
    tick();
    set_dec(OP_ADDI, 26, 0, 0, 1, 0, 0);
    rob_nex_idx = 2;
    tick();
    dec_valid = 0;
    check_eq("pre_rst_valid", dis_valid, 1);
    #2 rst_in = 0;
    #1;
    check_eq("async_rst_valid", {dis_valid, rob_flag, rs_flag, rf_write_flag}, 0);
    check_eq("async_rst_rd", dis_rd, 0);
    tick();
    rst_in = 1;
    set_dec(OP_ADDI, 27, 0, 0, 1, 0, 0);
    tick();
    dec_valid = 0;
    check_eq("rst_t1", dis_valid, 0);
    tick();
    check_eq("rst_t2_valid", dis_valid, 1);
    check_eq("rst_t2_rd", dis_rd, 27);
    tick();
    check_eq("rst_queue_empty", dis_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
Parametrised, registered successor to the combinational dispatch stage. Buffers decoded instructions in a QUEUE_DEPTH FIFO and resolves the head's operands through RF, then ROB, then the CDB. When the ROB and the target unit (RS or LSB) both have room, it pops one instruction per cycle into a registered dispatch output. Sits between the decoder and ROB/RS/LSB/RF, and absorbs back-pressure the old stage could not.

Parameters:
QUEUE_DEPTH, 4, FIFO entries; power of two, >=2
ROB_IDX_W, 4, ROB tag width
REG_IDX_W, 5, architectural register index width
CDB_PORTS, 2, number of CDB broadcast ports snooped

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-low reset
rdy_in  in  1  global ready; low = stall (no push, no pop)
flush_in  in  1  misprediction flush
dec_valid  in  1  decoder has an instruction
dec_ready  out  1  queue can accept (count < QUEUE_DEPTH)
dec_op  in  6  opcode (shared opcode constants)
dec_imm/dec_pc/dec_btb_pc  in  32 each  immediate, PC, predicted target
dec_btb_predict  in  1  predicted taken
dec_rd/dec_rs1/dec_rs2  in  REG_IDX_W each  register indices
dec_use_rs1/dec_use_rs2  in  1 each  operand used
rf_rs1_idx/rf_rs2_idx  out  REG_IDX_W  head source lookup (combinational from head)
rf_rs1_busy/rf_rs2_busy  in  1  register renamed
rf_rs1_val/rf_rs2_val  in  32  register value
rf_rs1_tag/rf_rs2_tag  in  ROB_IDX_W  renaming ROB tag
rob_rs1_idx/rob_rs2_idx  out  ROB_IDX_W  equals rf_rsN_tag
rob_rs1_ready/rob_rs2_ready  in  1  ROB entry has result
rob_rs1_val/rob_rs2_val  in  32  ROB result
rob_nex_idx  in  ROB_IDX_W  ROB tag for next allocation
rob_full/rs_full/lsb_full  in  1  no room; asserted while <=1 slot free
cdb_valid  in  CDB_PORTS  broadcast valid
cdb_tag  in  CDB_PORTS*ROB_IDX_W  broadcast tags (port i at [i*W +: W])
cdb_val  in  CDB_PORTS*32  broadcast values
dis_valid  out  1  dispatch register valid; rob_flag is identical
rob_flag/rs_flag/lsb_flag/rf_write_flag  out  1  destination enables
dis_op  out  6; dis_imm/dis_pc/dis_btb_pc  out  32; dis_btb_predict  out  1
dis_rd  out  REG_IDX_W; dis_rob_idx  out  ROB_IDX_W
dis_r1/dis_r2  out  1  operand ready
dis_v1/dis_v2  out  32  operand value (0 if not ready)
dis_q1/dis_q2  out  ROB_IDX_W  producer tag (0 if ready)

Behaviour:
- Reset (rst_in=0, async): head, tail and count = 0; every dis_* and flag output = 0.
- Push: dec_valid && dec_ready && rdy_in && !flush_in. Write tail entry; tail++ mod QUEUE_DEPTH.
- Pop: count>0 && rdy_in && !flush_in && !rob_full && (load/store ? !lsb_full : !rs_full). head++. Simultaneous push and pop leaves count unchanged.
- Output register, next cycle after a pop:
  - dis_valid=1 and fields loaded; dis_rob_idx = rob_nex_idx sampled in the pop cycle.
  - lsb_flag = load or store.
  - rs_flag = neither load nor store.
  - rf_write_flag = neither store nor branch.
  - With no pop, dis_valid and all flags = 0 next cycle; data fields hold.
- Operand N resolution at pop, first match wins:
  1. !use_rsN or rsN==0 -> ready, value 0.
  2. dis_valid && rf_write_flag && dis_rd==rsN -> not ready, tag = dis_rob_idx. Covers the in-flight rename not yet seen by RF.
  3. !rf_rsN_busy -> ready, rf value.
  4. rob_rsN_ready -> ready, rob value.
  5. cdb_valid[i] && cdb_tag[i]==rf tag -> ready, cdb value; lowest i wins.
  6. Otherwise not ready, tag = rf tag.
- The downstream unit snoops the CDB during the cycle dis_valid=1; no CDB capture happens in the output register.
- Flush: synchronous, highest priority. head=tail=count=0, dis_valid and flags = 0 next cycle; the same-cycle push and pop are dropped.
- rdy_in low: queue state holds; dis_valid = 0 next cycle.
- Full: dec_ready=0 at count==QUEUE_DEPTH even if a pop occurs that cycle. Pointers wrap modulo QUEUE_DEPTH.
- Latency: an empty queue with push at cycle t gives pop earliest at t+1 and dis_valid at t+2. Sustained throughput is 1 instruction per cycle.

Test Plan:
- ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back, rob_nex_idx 3 then 4 -> second dispatch has dis_r1=dis_r2=0, dis_q1=dis_q2=3 (hazard path).
- Head LW with lsb_full=1 for 3 cycles while rs_full=0 -> no pop, dis_valid=0; dispatches the cycle after lsb_full drops, lsb_flag=1, rs_flag=0.
- Push 4 with rob_full=1 -> dec_ready=0 after the 4th; release -> 4 dispatches on consecutive cycles, in order.
- rs1 busy with tag 7, ROB not ready, cdb_valid[1]=1 with tag 7 and value 0xDEAD_BEEF at pop -> dis_r1=1, dis_v1=0xDEADBEEF, dis_q1=0.
- 3 entries queued, flush_in pulsed together with dec_valid -> count=0, dec_ready=1, no dis_valid afterwards.
- rst_in asserted mid-stream -> all outputs 0 immediately without waiting for a clock edge; after release the first push dispatches at t+2.
